cmul_arbiter: RTL and testbench



---
 rtl/cmul_arb_pkg.sv | 22 ++
 rtl/cmul_arbiter_if.sv | 48 ++++
 rtl/cmul_tag_fifo.sv | 47 ++++
 rtl/cmul_arbiter.sv | 145 ++++++++++++++
 tb/tb_cmul_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmul_arb_pkg.sv
// cmul_arbiter shared types and width helpers.
// Imported by the interface, tag FIFO and arbiter top.
package cmul_arb_pkg;

  typedef enum logic {
    EMPTY,
    FULL
  } slot_state_e;

  function automatic int OP_W(int dw);
    return 4 * dw;
  endfunction

  function automatic int RES_W(int dw);
    return 4 * (dw + 1);
  endfunction

  function automatic int TAG_W(int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/cmul_arbiter_if.sv
// Requester fabric and multiplier handshake bundle.
// slave: the arbiter side; master: the surrounding fabric.
interface cmul_arbiter_if
  import cmul_arb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NREQ   = 4
);

  localparam int OPW = OP_W(DWIDTH);
  localparam int RSW = RES_W(DWIDTH);

  logic [NREQ-1:0]     req_val;
  logic [NREQ-1:0]     req_rdy;
  logic [NREQ*OPW-1:0] req_data;
  logic                mul_op_val;
  logic                mul_op_rdy;
  logic [OPW-1:0]      mul_op_data;
  logic                mul_res_val;
  logic                mul_res_rdy;
  logic [RSW-1:0]      mul_res_data;
  logic [NREQ-1:0]     rsp_val;
  logic [NREQ-1:0]     rsp_rdy;
  logic [RSW-1:0]      rsp_data;

  modport slave (
    input  req_val, req_data,
    input  mul_op_rdy,
    input  mul_res_val, mul_res_data,
    input  rsp_rdy,
    output req_rdy,
    output mul_op_val, mul_op_data,
    output mul_res_rdy,
    output rsp_val, rsp_data
  );

  modport master (
    output req_val, req_data,
    output mul_op_rdy,
    output mul_res_val, mul_res_data,
    output rsp_rdy,
    input  req_rdy,
    input  mul_op_val, mul_op_data,
    input  mul_res_rdy,
    input  rsp_val, rsp_data
  );

endinterface

// File: rtl/cmul_tag_fifo.sv
// In-order tag FIFO recording which requester owns each op.
// Pointers carry an extra MSB to tell full from empty.
module cmul_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  // Pointer update; a push never lands on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: only entries behind wp are read.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cmul_arbiter.sv
// Shares one complex multiplier among NREQ requesters.
// CMUL_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
module cmul_arbiter
  import cmul_arb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NREQ   = 4,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           sw_rst,
  cmul_arbiter_if.slave  bus,
  output logic           err_orphan
);

  localparam int OPW = OP_W(DWIDTH);
  localparam int TW  = TAG_W(NREQ);

  slot_state_e     state;
  slot_state_e     state_nxt;
  logic [OPW-1:0]  op_q;
  logic [TW-1:0]   gnt;
  logic [TW-1:0]   head;
  logic            any_val;
  logic            slot_free;
  logic            tag_full;
  logic            tag_empty;
  logic            accept;
  logic            pop;

  assign any_val   = |bus.req_val;
  assign slot_free = (state == EMPTY) || bus.mul_op_rdy;
  assign accept    = any_val && slot_free && !tag_full;
  assign pop       = bus.mul_res_val && bus.mul_res_rdy;

`ifdef CMUL_ARB_FIXED_PRIO_EN
  // Lowest-index valid requester wins.
  always_comb begin
    gnt = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req_val[i]) gnt = TW'(i);
  end
`else
  logic [TW-1:0] rr_ptr;

  function automatic logic [TW-1:0] wrap_add(
    logic [TW-1:0] p,
    int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return TW'(s);
  endfunction

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req_val[wrap_add(rr_ptr, k)])
        gnt = wrap_add(rr_ptr, k);
  end

  // Search restarts just past the last winner.
  always_ff @(posedge clk) begin
    if (sw_rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= wrap_add(gnt, 1);
  end
`endif

  // One-hot ready to the granted requester only.
  always_comb begin
    bus.req_rdy = '0;
    if (accept) bus.req_rdy[gnt] = 1'b1;
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (sw_rst)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  // Slot fills on accept, drains when the multiplier takes it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL: begin
        if (accept)
          state_nxt = FULL;
        else if (bus.mul_op_rdy)
          state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Operand register; holds while the multiplier stalls.
  always_ff @(posedge clk) begin
    if (sw_rst)
      op_q <= '0;
    else if (accept)
      op_q <= bus.req_data[int'(gnt)*OPW +: OPW];
  end

  assign bus.mul_op_val  = (state == FULL);
  assign bus.mul_op_data = op_q;

  cmul_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (TW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (sw_rst),
    .push  (accept),
    .pop   (pop),
    .din   (gnt),
    .full  (tag_full),
    .empty (tag_empty),
    .head  (head)
  );

  // Result valid steered to the owner of the oldest tag.
  always_comb begin
    bus.rsp_val = '0;
    if (bus.mul_res_val && !tag_empty)
      bus.rsp_val[head] = 1'b1;
  end

  assign bus.mul_res_rdy = !tag_empty && bus.rsp_rdy[head];
  assign bus.rsp_data    = bus.mul_res_data;

  // Sticky flag for a result nobody is waiting for.
  always_ff @(posedge clk) begin
    if (sw_rst)
      err_orphan <= 1'b0;
    else if (bus.mul_res_val && tag_empty)
      err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_cmul_arbiter.sv
// Directed and random bench for cmul_arbiter.
// Reference model: slot flag, tag queue and grant pointer.
module tb_cmul_arbiter;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int D   = 4;
  localparam int OPW = 4 * DW;

  logic clk = 1'b0;
  logic sw_rst;
  logic err_orphan;

  cmul_arbiter_if #(.DWIDTH(DW), .NREQ(N)) bus ();

  cmul_arbiter #(
    .DWIDTH (DW),
    .NREQ   (N),
    .DEPTH  (D)
  ) dut (
    .clk        (clk),
    .sw_rst     (sw_rst),
    .bus        (bus.slave),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit             m_full;
  logic [OPW-1:0] m_data;
  int             q[$];
  int             rr;
  bit             m_orph;

  logic [N-1:0]   e_rdy;
  logic [N-1:0]   e_rsp;
  int             e_gnt;
  logic [N-1:0]   g_seq [6];
  logic [N-1:0]   x_seq [6];
  logic [N-1:0]   r_seq [4];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_full = 0;
    m_data = '0;
    q.delete();
    rr     = 0;
    m_orph = 0;
  endtask

  function automatic int mgnt(logic [N-1:0] v);
`ifdef CMUL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
`else
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
`endif
    return 0;
  endfunction

  task automatic set_op(int i, logic [OPW-1:0] v);
    bus.req_data[i*OPW +: OPW] = v;
  endtask

  task automatic rnd_data();
    for (int i = 0; i < N; i++) set_op(i, $urandom);
    bus.mul_res_data = {4'($urandom), 32'($urandom)};
  endtask

  // Check every output against the model, then advance it.
  task automatic cyc();
    bit hd_rdy;
    @(negedge clk);
    e_gnt = mgnt(bus.req_val);
    e_rdy = '0;
    if (|bus.req_val && (!m_full || bus.mul_op_rdy) && q.size() < D)
      e_rdy[e_gnt] = 1'b1;
    e_rsp  = '0;
    hd_rdy = 0;
    if (q.size() > 0) begin
      hd_rdy = bus.rsp_rdy[q[0]];
      if (bus.mul_res_val) e_rsp[q[0]] = 1'b1;
    end
    chk("req_rdy", 64'(bus.req_rdy), 64'(e_rdy));
    chk("op_val", 64'(bus.mul_op_val), 64'(m_full));
    chk("op_data", 64'(bus.mul_op_data), 64'(m_data));
    chk("rsp_val", 64'(bus.rsp_val), 64'(e_rsp));
    chk("res_rdy", 64'(bus.mul_res_rdy), 64'(hd_rdy));
    chk("rsp_data", 64'(bus.rsp_data), 64'(bus.mul_res_data));
    chk("orphan", 64'(err_orphan), 64'(m_orph));
    @(posedge clk);
    if (sw_rst) begin
      mreset();
    end else begin
      if (bus.mul_res_val && q.size() == 0) m_orph = 1;
      if (bus.mul_res_val && hd_rdy) void'(q.pop_front());
      if (e_rdy != '0) begin
        q.push_back(e_gnt);
        m_full = 1;
        m_data = bus.req_data[e_gnt*OPW +: OPW];
        rr     = (e_gnt + 1) % N;
      end else if (bus.mul_op_rdy) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic do_rst();
    sw_rst = 1'b1;
    cyc();
    sw_rst = 1'b0;
  endtask

  initial begin
`ifdef CMUL_ARB_FIXED_PRIO_EN
    g_seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    r_seq = '{4'h1, 4'h1, 4'h1, 4'h2};
`else
    g_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    r_seq = '{4'h2, 4'h4, 4'h8, 4'h2};
`endif
    sw_rst           = 1'b1;
    bus.req_val      = '0;
    bus.mul_op_rdy   = 1'b0;
    bus.mul_res_val  = 1'b0;
    bus.rsp_rdy      = '0;
    rnd_data();
    repeat (2) @(posedge clk);
    #1;
    sw_rst = 1'b0;
    mreset();

    chk("rst_op_val", 64'(bus.mul_op_val), 64'(0));
    chk("rst_op_data", 64'(bus.mul_op_data), 64'(0));
    chk("rst_orphan", 64'(err_orphan), 64'(0));
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'(0));
    chk("rst_res_rdy", 64'(bus.mul_res_rdy), 64'(0));

    bus.req_val    = 4'b0100;
    set_op(2, 32'h01020304);
    bus.mul_op_rdy = 1'b1;
    bus.rsp_rdy    = 4'hF;
    cyc();
    bus.req_val = '0;
    #1;
    chk("t1_op_val", 64'(bus.mul_op_val), 64'(1));
    chk("t1_op_data", 64'(bus.mul_op_data), 64'h01020304);
    cyc();
    cyc();
    bus.mul_res_val  = 1'b1;
    bus.mul_res_data = 36'h0A5;
    #1;
    chk("t1_rsp_val", 64'(bus.rsp_val), 64'(4'b0100));
    chk("t1_rsp_data", 64'(bus.rsp_data), 64'h0A5);
    cyc();
    bus.mul_res_val = 1'b0;

    do_rst();
    bus.req_val = 4'hF;
    rnd_data();
    for (int c = 0; c < 6; c++) begin
      #1;
      x_seq[c] = bus.req_rdy;
      cyc();
    end
    for (int c = 0; c < 6; c++)
      chk("t2_gnt", 64'(x_seq[c]), 64'(g_seq[c]));

    bus.req_val     = 4'b0010;
    bus.mul_res_val = 1'b1;
    #1;
    chk("t4_full_rdy", 64'(bus.req_rdy), 64'(0));
    cyc();
    bus.mul_res_val = 1'b0;
    #1;
    chk("t4_push_rdy", 64'(bus.req_rdy), 64'(4'b0010));
    cyc();
    #1;
    chk("t4_refull", 64'(bus.req_rdy), 64'(0));
    bus.req_val     = '0;
    bus.mul_res_val = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rnd_data();
      #1;
      chk("t2_ret", 64'(bus.rsp_val), 64'(r_seq[c]));
      cyc();
    end
    bus.mul_res_val = 1'b0;

    bus.mul_op_rdy = 1'b0;
    bus.req_val    = 4'b1000;
    set_op(3, 32'hA1B2C3D4);
    cyc();
    bus.req_val = 4'b0001;
    set_op(0, 32'h55667788);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_hold", 64'(bus.mul_op_data), 64'hA1B2C3D4);
      chk("t3_rdy", 64'(bus.req_rdy), 64'(0));
      cyc();
    end
    bus.mul_op_rdy = 1'b1;
    #1;
    chk("t3_release", 64'(bus.req_rdy), 64'(4'b0001));
    cyc();
    bus.req_val = '0;
    #1;
    chk("t3_next", 64'(bus.mul_op_data), 64'h55667788);
    do_rst();

    bus.req_val = 4'b0010;
    cyc();
    bus.req_val     = '0;
    bus.mul_res_val = 1'b1;
    bus.rsp_rdy     = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t5_res_rdy", 64'(bus.mul_res_rdy), 64'(0));
      chk("t5_rsp_val", 64'(bus.rsp_val), 64'(4'b0010));
      cyc();
    end
    bus.rsp_rdy = 4'hF;
    #1;
    chk("t5_release", 64'(bus.mul_res_rdy), 64'(1));
    cyc();
    bus.mul_res_val = 1'b0;

    do_rst();
    bus.mul_res_val = 1'b1;
    cyc();
    bus.mul_res_val = 1'b0;
    chk("t6_set", 64'(err_orphan), 64'(1));
    repeat (3) cyc();
    chk("t6_sticky", 64'(err_orphan), 64'(1));
    do_rst();
    chk("t6_clear", 64'(err_orphan), 64'(0));

`ifdef CMUL_ARB_FIXED_PRIO_EN
    bus.req_val = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("fp_gnt", 64'(bus.req_rdy), 64'(4'b0001));
      cyc();
    end
    bus.req_val = '0;
    do_rst();
`endif

    for (int c = 0; c < 400; c++) begin
      bus.req_val     = N'($urandom);
      bus.mul_op_rdy  = ($urandom_range(3, 0) != 0);
      bus.rsp_rdy     = N'($urandom) | N'($urandom);
      bus.mul_res_val = (q.size() > 0) ? 1'($urandom)
                        : ($urandom_range(31, 0) == 0);
      sw_rst          = ($urandom_range(99, 0) == 0);
      rnd_data();
      cyc();
    end
    sw_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
